// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the mode encoding, the bounce direction values and the default bank width.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ALL    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic LEFT      = 1'b0;
    localparam logic RIGHT     = 1'b1;
    localparam int   N_LED_DEF = 16;

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MODE_ALL:    r = MODE_CHASE;
            MODE_CHASE:  r = MODE_BOUNCE;
            MODE_BOUNCE: r = MODE_BLINK;
            MODE_BLINK:  r = MODE_ALL;
            default:     r = MODE_ALL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-side bundle of the sequencer: raw switch/button inputs and LED/mode outputs.
// The board (or bench) is the master; the sequencer is the slave.
interface led_pattern_sequencer_if #(
    parameter int N_LED = 16
);
    import led_seq_pkg::*;

    logic             sw0;
    logic             btn_mode;
    logic [N_LED-1:0] led;
    mode_t            mode;

    modport master (output sw0, output btn_mode, input led, input mode);
    modport slave  (input sw0, input btn_mode, output led, output mode);

endinterface

// File: rtl/led_pattern_sequencer_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, count stable disagreement, accept and flag 0->1 acceptances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    rise_r  <= sync2_r;
                    cnt_r   <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign level      = level_r;
    assign rise_pulse = rise_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Clocked LED pattern controller: four modes stepped by a prescaler tick while sw0 runs.
// LED and mode outputs are registered from next-state so changes land one cycle after tick/adv.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED           = N_LED_DEF,
    parameter int TICK_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    led_pattern_sequencer_if.slave   bus
);
    localparam int            PW        = $clog2(N_LED);
    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [PW-1:0] POS_LAST  = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_PEN   = PW'(N_LED - 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic             sw_sync1_r, sw_sync2_r;
    logic             btn_level_s, btn_rise_s;
    logic             run_s, adv_s, tick_s;
    mode_t            mode_r, mode_nxt_s;
    logic [PW-1:0]    pos_r, pos_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic             blink_on_r, blink_nxt_s;
    logic [TW-1:0]    presc_r, presc_nxt_s;
    logic [N_LED-1:0] led_r, led_nxt_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (bus.btn_mode),
        .level      (btn_level_s),
        .rise_pulse (btn_rise_s)
    );

    // Two-stage synchroniser for the run switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_r <= 1'b0;
            sw_sync2_r <= 1'b0;
        end else begin
            sw_sync1_r <= bus.sw0;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    assign run_s = sw_sync2_r;
    assign adv_s = btn_rise_s & btn_level_s;

    // Next-state: adv beats tick; run=0 freezes the pattern and clears the prescaler.
    always_comb begin
        mode_nxt_s  = mode_r;
        pos_nxt_s   = pos_r;
        dir_nxt_s   = dir_r;
        blink_nxt_s = blink_on_r;
        presc_nxt_s = presc_r;
        tick_s      = run_s && (presc_r == TICK_LAST);
        led_nxt_s   = {N_LED{1'b0}};
        if (adv_s) begin
            mode_nxt_s  = next_mode(mode_r);
            pos_nxt_s   = POS_ZERO;
            dir_nxt_s   = LEFT;
            blink_nxt_s = 1'b1;
            presc_nxt_s = {TW{1'b0}};
        end else if (!run_s) begin
            presc_nxt_s = {TW{1'b0}};
        end else if (tick_s) begin
            presc_nxt_s = {TW{1'b0}};
            case (mode_r)
                MODE_CHASE: begin
                    if (pos_r == POS_LAST) pos_nxt_s = POS_ZERO;
                    else                   pos_nxt_s = pos_r + POS_ONE;
                end
                MODE_BOUNCE: begin
                    if (dir_r == LEFT) begin
                        if (pos_r == POS_LAST) begin
                            pos_nxt_s = POS_PEN;
                            dir_nxt_s = RIGHT;
                        end else begin
                            pos_nxt_s = pos_r + POS_ONE;
                        end
                    end else begin
                        if (pos_r == POS_ZERO) begin
                            pos_nxt_s = POS_ONE;
                            dir_nxt_s = LEFT;
                        end else begin
                            pos_nxt_s = pos_r - POS_ONE;
                        end
                    end
                end
                MODE_BLINK: blink_nxt_s = ~blink_on_r;
                default:    blink_nxt_s = blink_on_r;
            endcase
        end else begin
            presc_nxt_s = presc_r + TICK_ONE;
        end

        if (!run_s) begin
            led_nxt_s = {N_LED{1'b0}};
        end else begin
            case (mode_nxt_s)
                MODE_ALL:    led_nxt_s = {N_LED{1'b1}};
                MODE_CHASE,
                MODE_BOUNCE: led_nxt_s = {{(N_LED-1){1'b0}}, 1'b1} << pos_nxt_s;
                MODE_BLINK:  led_nxt_s = blink_nxt_s ? {N_LED{1'b1}} : {N_LED{1'b0}};
                default:     led_nxt_s = {N_LED{1'b0}};
            endcase
        end
    end

    // Mode FSM, pattern state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r     <= MODE_ALL;
            pos_r      <= POS_ZERO;
            dir_r      <= LEFT;
            blink_on_r <= 1'b1;
            presc_r    <= {TW{1'b0}};
            led_r      <= {N_LED{1'b0}};
        end else begin
            mode_r     <= mode_nxt_s;
            pos_r      <= pos_nxt_s;
            dir_r      <= dir_nxt_s;
            blink_on_r <= blink_nxt_s;
            presc_r    <= presc_nxt_s;
            led_r      <= led_nxt_s;
        end
    end

    assign bus.led  = led_r;
    assign bus.mode = mode_r;

endmodule
